vc_wrr_arbiter: RTL and testbench
=================================

# vc_wrr_arbiter

Weighted round-robin arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the PCIe transmission-layer logic. Each cycle it pops at most one word from an eligible VC FIFO and registers it, with the matching push, into the D FIFO selected by the word's destination bit. A destination whose almost-full flag is set applies backpressure. The arbiter runs only while the top-level flow-control FSM holds it enabled (active state).

## Interface
- data_width, 6, word width; bit 4 is the destination select (0 → D0, 1 → D1)
- VC0_WEIGHT, 3, contested grants VC0 may take in a row before VC1 gets one (1..15)
- CNT_WIDTH, 4, width of the weight counter
- clk  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-low; 0 = held in reset
- enable  input  1  1 = arbitration allowed (driven from the active state of the top FSM)
- vc0_empty, vc1_empty  input  1 each  VC FIFO empty flags
- vc0_data, vc1_data  input  data_width each  VC FIFO head words; show-ahead, valid whenever not empty
- d0_almost_full, d1_almost_full  input  1 each  destination backpressure
- vc0_pop, vc1_pop  output  1 each  combinational pops, at most one high
- d0_push, d1_push  output  1 each  registered pushes, at most one high
- data_out  output  data_width  registered word for the pushed D FIFO
- arb_idle  output  1  registered; both VCs empty and no push issued

## Operation
- Eligibility. elig0 = enable & reset & !vc0_empty & !af(vc0_data[4]). elig1 is defined the same way for VC1. af(0) = d0_almost_full and af(1) = d1_almost_full.
- Grant with weight counter wc:
  - Both eligible, wc < VC0_WEIGHT: grant VC0, then wc++.
  - Both eligible, wc == VC0_WEIGHT: grant VC1, then wc = 0.
  - Only VC1 eligible: grant VC1, then wc = 0.
  - Only VC0 eligible: grant VC0; wc is unchanged, because only contested grants count.
  - Neither eligible: no grant; wc is held.
- vcN_pop is driven high in the same cycle as grant N.
- Next edge after a grant: data_out = granted head word. d0_push = !word[4] and d1_push = word[4]. With no grant, both pushes are 0 and data_out holds its last value.
- arb_idle next value = vc0_empty & vc1_empty & no grant this cycle.
- enable low: no new pops. A push already registered from the previous cycle still appears. wc is held.
- Reset low (synchronous): pops are forced to 0 combinationally. At the next edge: pushes 0, data_out 0, wc 0, arb_idle 1. A grant in flight is discarded.
- Almost-full threshold sizing is a system requirement: each D FIFO asserts almost_full with at least 1 free entry, because one push can already be in flight.

## Timing
- Pop-to-push latency is 1 cycle. Sustained throughput is 1 word per cycle.
- Reset values: vc0_pop=0, vc1_pop=0, d0_push=0, d1_push=0, data_out=0, arb_idle=1, wc=0.
- Backpressure takes effect in the same cycle: an almost_full flag seen at edge t blocks the pop at t.
- An empty or almost_full flag that changes in the grant cycle is sampled combinationally. There is no stale eligibility and no double pop.
- wc never exceeds VC0_WEIGHT. There is no wrap-around.

## Structure
- Shared include: destination-bit index (4), VC0_WEIGHT default, and the D0/D1 select encoding. The demux and other full_logic blocks reuse these.
- Sub-module vc_wrr_counter holds wc plus the contested-grant decision. It outputs favor_vc1 = (wc == VC0_WEIGHT).
- Top level: eligibility logic, pop generation, output registers, idle flag.

## Test plan
- Reset: reset=0 for 2 cycles with vc0_empty=0 and vc0_data=6'b110101. Required: pops 0 throughout; pushes 0, data_out 0 and arb_idle 1 after the first edge.
- Single VC: VC0 holds 6'b110101 (bit4=1), d1_almost_full=0, enable=1. Required: vc0_pop at cycle t; d1_push=1 and data_out=6'b110101 at t+1.
- Weighting: both VCs non-empty continuously, destinations free, VC0_WEIGHT=3. Required grant sequence: VC0, VC0, VC0, VC1, VC0, VC0, VC0, VC1.
- Backpressure: d0_almost_full=1, VC0 head 6'b100101 (→D0), VC1 head 6'b110110 (→D1). Required: only vc1_pop; d1_push=1 next cycle; wc=0. After release, VC0 is granted.
- Enable drop: deassert enable the cycle after a VC0 grant. Required: the pending push still appears, no further pops occur, and wc is held.
- Mid-stream reset: drive reset=0 in a grant cycle. Required: pop forced 0 that cycle; pushes 0 and data_out 0 at the next edge.

Source files
------------

// File: rtl/vc_wrr_arbiter_pkg.sv
// vc_wrr_arbiter_pkg: shared constants for the VC-to-destination arbiter and demux blocks.
package vc_wrr_arbiter_pkg;
   localparam int DEST_BIT = 4;
   localparam int VC0_WEIGHT_DEF = 3;
   typedef enum logic {SEL_D0 = 1'b0, SEL_D1 = 1'b1} dsel_t;
endpackage

// File: rtl/vc_wrr_counter.sv
// vc_wrr_counter: weight counter and grant decision between two eligible virtual channels.
module vc_wrr_counter
   import vc_wrr_arbiter_pkg::*;
#(
   parameter int VC0_WEIGHT = VC0_WEIGHT_DEF,
   parameter int CNT_WIDTH  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic elig0,
   input  logic elig1,
   output logic grant0,
   output logic grant1,
   output logic favor_vc1
);
   logic [CNT_WIDTH-1:0] wc;
   assign favor_vc1 = wc == CNT_WIDTH'(VC0_WEIGHT);
   assign grant1 = elig1 & (!elig0 | favor_vc1);
   assign grant0 = elig0 & !grant1;
   // Any VC1 grant restarts the run; only contested VC0 grants advance it.
   always_ff @(posedge clk)
      if (!reset) wc <= '0;
      else if (grant1) wc <= '0;
      else if (grant0 & elig1) wc <= wc + 1'b1;
endmodule

// File: rtl/vc_wrr_arbiter.sv
// vc_wrr_arbiter: weighted round-robin transfer from two VC FIFOs into two destination FIFOs.
module vc_wrr_arbiter
   import vc_wrr_arbiter_pkg::*;
#(
   parameter int data_width = 6,
   parameter int VC0_WEIGHT = VC0_WEIGHT_DEF,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [data_width-1:0] vc0_data,
   input  logic [data_width-1:0] vc1_data,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   output logic                  vc0_pop,
   output logic                  vc1_pop,
   output logic                  d0_push,
   output logic                  d1_push,
   output logic [data_width-1:0] data_out,
   output logic                  arb_idle
);
   dsel_t sel0, sel1, wsel;
   logic af0, af1, elig0, elig1, grant, favor_vc1;
   logic [data_width-1:0] word;
   assign sel0  = dsel_t'(vc0_data[DEST_BIT]);
   assign sel1  = dsel_t'(vc1_data[DEST_BIT]);
   assign af0   = (sel0 == SEL_D1) ? d1_almost_full : d0_almost_full;
   assign af1   = (sel1 == SEL_D1) ? d1_almost_full : d0_almost_full;
   assign elig0 = enable & reset & !vc0_empty & !af0;
   assign elig1 = enable & reset & !vc1_empty & !af1;
   vc_wrr_counter #(.VC0_WEIGHT(VC0_WEIGHT), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk(clk), .reset(reset), .elig0(elig0), .elig1(elig1),
      .grant0(vc0_pop), .grant1(vc1_pop), .favor_vc1(favor_vc1)
   );
   assign grant = vc0_pop | vc1_pop;
   assign word  = vc1_pop ? vc1_data : vc0_data;
   assign wsel  = dsel_t'(word[DEST_BIT]);
   always_ff @(posedge clk)
      if (!reset) begin
         d0_push  <= 1'b0;
         d1_push  <= 1'b0;
         data_out <= '0;
         arb_idle <= 1'b1;
      end else begin
         d0_push  <= grant & (wsel == SEL_D0);
         d1_push  <= grant & (wsel == SEL_D1);
         data_out <= grant ? word : data_out;
         arb_idle <= vc0_empty & vc1_empty & !grant;
      end
endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// tb_vc_wrr_arbiter: directed self-checking bench for vc_wrr_arbiter.
module tb_vc_wrr_arbiter;
   logic clk = 1'b0, reset, enable, vc0_empty, vc1_empty, d0_almost_full, d1_almost_full;
   logic [5:0] vc0_data, vc1_data, data_out;
   logic vc0_pop, vc1_pop, d0_push, d1_push, arb_idle;
   int n = 0, e = 0;

   vc_wrr_arbiter #(.data_width(6), .VC0_WEIGHT(3), .CNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_data(vc0_data), .vc1_data(vc1_data), .d0_almost_full(d0_almost_full),
      .d1_almost_full(d1_almost_full), .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
      .d0_push(d0_push), .d1_push(d1_push), .data_out(data_out), .arb_idle(arb_idle)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; vc0_empty = 1'b0; vc1_empty = 1'b1;
      vc0_data = 6'b110101; vc1_data = 6'b000000; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      #1;
      n++; if ({vc0_pop, vc1_pop} !== 2'b00) begin e++; $display("FAIL reset_pop0: got %b want 00", {vc0_pop, vc1_pop}); end
      step();
      n++; if ({d0_push, d1_push} !== 2'b00) begin e++; $display("FAIL reset_push: got %b want 00", {d0_push, d1_push}); end
      n++; if (data_out !== 6'd0) begin e++; $display("FAIL reset_data: got %b want 000000", data_out); end
      n++; if (arb_idle !== 1'b1) begin e++; $display("FAIL reset_idle: got %b want 1", arb_idle); end
      n++; if (dut.u_cnt.wc !== 4'd0) begin e++; $display("FAIL reset_wc: got %0d want 0", dut.u_cnt.wc); end
      step();
      n++; if ({vc0_pop, vc1_pop} !== 2'b00) begin e++; $display("FAIL reset_pop1: got %b want 00", {vc0_pop, vc1_pop}); end
   endtask

   task automatic test_single_vc();
      reset = 1'b1;
      #1;
      n++; if ({vc0_pop, vc1_pop} !== 2'b10) begin e++; $display("FAIL single_pop: got %b want 10", {vc0_pop, vc1_pop}); end
      step();
      n++; if ({d0_push, d1_push} !== 2'b01) begin e++; $display("FAIL single_push: got %b want 01", {d0_push, d1_push}); end
      n++; if (data_out !== 6'b110101) begin e++; $display("FAIL single_data: got %b want 110101", data_out); end
      n++; if (dut.u_cnt.wc !== 4'd0) begin e++; $display("FAIL single_wc: got %0d want 0", dut.u_cnt.wc); end
      vc0_empty = 1'b1;
      #1;
      n++; if (vc0_pop !== 1'b0) begin e++; $display("FAIL single_nopop: got %b want 0", vc0_pop); end
      step();
      n++; if ({d0_push, d1_push} !== 2'b00) begin e++; $display("FAIL single_nopush: got %b want 00", {d0_push, d1_push}); end
      n++; if (data_out !== 6'b110101) begin e++; $display("FAIL single_hold: got %b want 110101", data_out); end
      n++; if (arb_idle !== 1'b1) begin e++; $display("FAIL single_idle: got %b want 1", arb_idle); end
   endtask

   task automatic test_weighting();
      logic [7:0] seq = 8'b1000_1000;
      vc0_empty = 1'b0; vc1_empty = 1'b0; vc0_data = 6'b000001; vc1_data = 6'b010010;
      for (int i = 0; i < 8; i++) begin
         #1;
         n++; if ({vc0_pop, vc1_pop} !== {!seq[i], seq[i]})
            begin e++; $display("FAIL weight_pop%0d: got %b want %b", i, {vc0_pop, vc1_pop}, {!seq[i], seq[i]}); end
         step();
         n++; if ({d0_push, d1_push, data_out} !== (seq[i] ? {2'b01, 6'b010010} : {2'b10, 6'b000001}))
            begin e++; $display("FAIL weight_push%0d: got %b/%b", i, {d0_push, d1_push}, data_out); end
         n++; if (arb_idle !== 1'b0) begin e++; $display("FAIL weight_idle%0d: got %b want 0", i, arb_idle); end
      end
      n++; if (dut.u_cnt.wc !== 4'd0) begin e++; $display("FAIL weight_wc: got %0d want 0", dut.u_cnt.wc); end
   endtask

   task automatic test_backpressure();
      vc0_data = 6'b100101; vc1_data = 6'b110110;
      step();
      n++; if (dut.u_cnt.wc !== 4'd1) begin e++; $display("FAIL bp_pre_wc: got %0d want 1", dut.u_cnt.wc); end
      d0_almost_full = 1'b1;
      #1;
      n++; if ({vc0_pop, vc1_pop} !== 2'b01) begin e++; $display("FAIL bp_pop: got %b want 01", {vc0_pop, vc1_pop}); end
      step();
      n++; if ({d0_push, d1_push} !== 2'b01) begin e++; $display("FAIL bp_push: got %b want 01", {d0_push, d1_push}); end
      n++; if (data_out !== 6'b110110) begin e++; $display("FAIL bp_data: got %b want 110110", data_out); end
      n++; if (dut.u_cnt.wc !== 4'd0) begin e++; $display("FAIL bp_wc: got %0d want 0", dut.u_cnt.wc); end
      d0_almost_full = 1'b0;
      #1;
      n++; if ({vc0_pop, vc1_pop} !== 2'b10) begin e++; $display("FAIL bp_release_pop: got %b want 10", {vc0_pop, vc1_pop}); end
      step();
      n++; if ({d0_push, d1_push, data_out} !== {2'b10, 6'b100101})
         begin e++; $display("FAIL bp_release_push: got %b/%b want 10/100101", {d0_push, d1_push}, data_out); end
   endtask

   task automatic test_enable_drop();
      #1;
      n++; if (vc0_pop !== 1'b1) begin e++; $display("FAIL en_grant: got %b want 1", vc0_pop); end
      step();
      enable = 1'b0;
      #1;
      n++; if ({vc0_pop, vc1_pop} !== 2'b00) begin e++; $display("FAIL en_pop: got %b want 00", {vc0_pop, vc1_pop}); end
      n++; if (d0_push !== 1'b1) begin e++; $display("FAIL en_pending: got %b want 1", d0_push); end
      step();
      n++; if ({d0_push, d1_push} !== 2'b00) begin e++; $display("FAIL en_push: got %b want 00", {d0_push, d1_push}); end
      n++; if (dut.u_cnt.wc !== 4'd2) begin e++; $display("FAIL en_wc: got %0d want 2", dut.u_cnt.wc); end
      step();
      n++; if ({vc0_pop, vc1_pop, d0_push, d1_push} !== 4'b0000)
         begin e++; $display("FAIL en_quiet: got %b want 0000", {vc0_pop, vc1_pop, d0_push, d1_push}); end
      n++; if (dut.u_cnt.wc !== 4'd2) begin e++; $display("FAIL en_wc_hold: got %0d want 2", dut.u_cnt.wc); end
   endtask

   task automatic test_mid_reset();
      enable = 1'b1;
      #1;
      n++; if (vc0_pop !== 1'b1) begin e++; $display("FAIL mr_grant: got %b want 1", vc0_pop); end
      reset = 1'b0;
      #1;
      n++; if ({vc0_pop, vc1_pop} !== 2'b00) begin e++; $display("FAIL mr_pop: got %b want 00", {vc0_pop, vc1_pop}); end
      step();
      n++; if ({d0_push, d1_push, data_out} !== 8'd0)
         begin e++; $display("FAIL mr_out: got %b/%b want 00/000000", {d0_push, d1_push}, data_out); end
      n++; if ({arb_idle, dut.u_cnt.wc} !== {1'b1, 4'd0})
         begin e++; $display("FAIL mr_idle_wc: got %b/%0d want 1/0", arb_idle, dut.u_cnt.wc); end
      reset = 1'b1;
      #1;
      n++; if ({vc0_pop, vc1_pop} !== 2'b10) begin e++; $display("FAIL mr_resume: got %b want 10", {vc0_pop, vc1_pop}); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] w [4] = '{6'b010001, 6'b000010, 6'b010011, 6'b000100};
      logic [5:0] cur;
      vc1_empty = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cur = w[i];
         vc0_data = cur;
         #1;
         n++; if (vc0_pop !== 1'b1) begin e++; $display("FAIL b2b_pop%0d: got %b want 1", i, vc0_pop); end
         step();
         n++; if ({d0_push, d1_push, data_out} !== {!cur[4], cur[4], cur})
            begin e++; $display("FAIL b2b_push%0d: got %b/%b want %b/%b", i, {d0_push, d1_push}, data_out, {!cur[4], cur[4]}, cur); end
      end
      d1_almost_full = 1'b1; vc0_data = 6'b010101;
      #1;
      n++; if (vc0_pop !== 1'b0) begin e++; $display("FAIL b2b_af_pop: got %b want 0", vc0_pop); end
      step();
      n++; if ({d0_push, d1_push, data_out} !== {2'b00, 6'b000100})
         begin e++; $display("FAIL b2b_af_push: got %b/%b want 00/000100", {d0_push, d1_push}, data_out); end
   endtask

   initial begin
      test_reset();
      test_single_vc();
      test_weighting();
      test_backpressure();
      test_enable_drop();
      test_mid_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, e);
      $finish;
   end
endmodule
